voice_scheduler: RTL

Frame sequencer for the shared three-voice generator datapath. On each sample tick it snapshots per-voice config and runs voices 0, 1, 2 back-to-back through the generator's start/ready handshake. It holds each voice's selection stable until that voice completes, then captures and registers the three per-voice samples for the filter/mixer stage. It also flags overruns and hung handshakes.

---
 rtl/voice_pkg.sv | 37 +++
 rtl/voice_scheduler_if.sv | 26 ++
 rtl/voice_cfg_mux.sv | 31 +++
 rtl/voice_scheduler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/voice_pkg.sv
// Shared types and constants for the three-voice frame sequencer.
// Holds the FSM state enum, the per-voice config struct and sign-extension helpers.
package voice_pkg;

    localparam int NUM_VOICES = 3;
    localparam int WAVE_W     = 10;
    localparam int MIX_W      = 12;
    localparam int FREQ_W     = 16;
    localparam int PW_W       = 12;
    localparam int SEL_W      = 4;

    localparam logic [SEL_W-1:0] WAVE_TRI   = 4'b0001;
    localparam logic [SEL_W-1:0] WAVE_SAW   = 4'b0010;
    localparam logic [SEL_W-1:0] WAVE_PULSE = 4'b0100;
    localparam logic [SEL_W-1:0] WAVE_NOISE = 4'b1000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        ADVANCE = 3'd3,
        DONE    = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [PW_W-1:0]   pw;
        logic [SEL_W-1:0]  wave_sel;
        logic              sync;
        logic              ring;
    } voice_cfg_t;

    function automatic logic signed [MIX_W-1:0] sext_mix(input logic signed [WAVE_W-1:0] w);
        return {{(MIX_W-WAVE_W){w[WAVE_W-1]}}, w};
    endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Start/ready handshake and selected-voice config bus to the shared generator.
// start_o is a one-cycle request; the generator answers with a one-cycle ready_i carrying wave_i.
interface voice_scheduler_if;
    import voice_pkg::*;

    logic                     start_o;
    logic [1:0]               act_voice_o;
    logic [FREQ_W-1:0]        freq_word_o;
    logic [PW_W-1:0]          pw_word_o;
    logic [SEL_W-1:0]         wave_sel_o;
    logic                     sync_o;
    logic                     ring_mod_o;
    logic                     ready_i;
    logic signed [WAVE_W-1:0] wave_i;

    modport master (
        output start_o, act_voice_o, freq_word_o, pw_word_o, wave_sel_o, sync_o, ring_mod_o,
        input  ready_i, wave_i
    );

    modport slave (
        input  start_o, act_voice_o, freq_word_o, pw_word_o, wave_sel_o, sync_o, ring_mod_o,
        output ready_i, wave_i
    );

endinterface

// File: rtl/voice_cfg_mux.sv
// Per-voice config snapshot plus a registered selection of one voice's config.
// On load the selection comes straight from the live inputs so voice 0 is valid in the very next cycle.
module voice_cfg_mux
    import voice_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         load_i,
    input  logic                         sel_en_i,
    input  logic [1:0]                   sel_idx_i,
    input  voice_cfg_t [NUM_VOICES-1:0]  cfg_i,
    output voice_cfg_t                   sel_o
);

    voice_cfg_t [NUM_VOICES-1:0] snap_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_q <= '0;
            sel_o  <= '0;
        end else begin
            if (load_i) begin
                snap_q <= cfg_i;
            end
            if (sel_en_i) begin
                sel_o <= load_i ? cfg_i[sel_idx_i] : snap_q[sel_idx_i];
            end
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Frame sequencer: per sample tick, runs voices 0..2 through the generator handshake and registers their samples.
// Build option VOICE_SCHED_MIX_EN adds mix_o, the registered sum of the three voice samples.
module voice_scheduler
    import voice_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8
)
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     sample_tick_i,
    input  logic                     clr_status_i,
    input  logic [47:0]              freq_words_i,
    input  logic [35:0]              pw_words_i,
    input  logic [11:0]              wave_sels_i,
    input  logic [2:0]               sync_en_i,
    input  logic [2:0]               ring_en_i,
    voice_scheduler_if.master        gen,
    output logic signed [WAVE_W-1:0] voice0_o,
    output logic signed [WAVE_W-1:0] voice1_o,
    output logic signed [WAVE_W-1:0] voice2_o,
    output logic                     frame_valid_o,
    output logic                     busy_o,
    output logic                     overrun_o,
    output logic                     timeout_o,
    output sched_state_e             state_o
`ifdef VOICE_SCHED_MIX_EN
    ,
    output logic signed [MIX_W-1:0]  mix_o
`endif
);

    localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] LAST_VOICE = 2'(NUM_VOICES - 1);

    sched_state_e               state, next_state;
    logic [1:0]                 v;
    logic [7:0]                 cnt;
    logic signed [WAVE_W-1:0]   voice_q [NUM_VOICES];
    voice_cfg_t [NUM_VOICES-1:0] cfg_in;
    voice_cfg_t                 sel_cfg;

    logic       load, capture, expire, sel_en, last_voice;
    logic [1:0] sel_idx;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_cfg
        assign cfg_in[i] = '{
            freq:     freq_words_i[16*i +: 16],
            pw:       pw_words_i[12*i +: 12],
            wave_sel: wave_sels_i[4*i +: 4],
            sync:     sync_en_i[i],
            ring:     ring_en_i[i]
        };
    end

    voice_cfg_mux u_cfg_mux (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (load),
        .sel_en_i  (sel_en),
        .sel_idx_i (sel_idx),
        .cfg_i     (cfg_in),
        .sel_o     (sel_cfg)
    );

    always_comb begin
        next_state = state;
        load       = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        sel_en     = 1'b0;
        sel_idx    = '0;
        last_voice = (v == LAST_VOICE);
        unique case (state)
            IDLE: begin
                if (sample_tick_i) begin
                    load       = 1'b1;
                    sel_en     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (gen.ready_i) begin
                    capture    = 1'b1;
                    next_state = ADVANCE;
                end else if (cnt == CNT_LAST) begin
                    expire     = 1'b1;
                    next_state = ADVANCE;
                end
            end
            ADVANCE: begin
                if (last_voice) begin
                    next_state = DONE;
                end else begin
                    sel_en     = 1'b1;
                    sel_idx    = v + 2'd1;
                    next_state = ISSUE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // v only moves in ADVANCE, so the generator sees a stable index through its write-back.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            v             <= '0;
            cnt           <= '0;
            frame_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            gen.start_o   <= 1'b0;
        end else begin
            state         <= next_state;
            gen.start_o   <= (next_state == ISSUE);
            frame_valid_o <= (next_state == DONE);
            busy_o        <= (next_state != IDLE);
            if (load) begin
                v <= '0;
            end else if (state == ADVANCE && !last_voice) begin
                v <= v + 2'd1;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_q[i] <= '0;
            end
        end else if (capture) begin
            voice_q[v] <= gen.wave_i;
        end else if (expire) begin
            voice_q[v] <= '0;
        end
    end

    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overrun_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            if (sample_tick_i && state != IDLE) begin
                overrun_o <= 1'b1;
            end else if (clr_status_i) begin
                overrun_o <= 1'b0;
            end
            if (expire) begin
                timeout_o <= 1'b1;
            end else if (clr_status_i) begin
                timeout_o <= 1'b0;
            end
        end
    end

`ifdef VOICE_SCHED_MIX_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mix_o <= '0;
        end else if (next_state == DONE) begin
            mix_o <= sext_mix(voice_q[0]) + sext_mix(voice_q[1]) + sext_mix(voice_q[2]);
        end
    end
`endif

    assign gen.act_voice_o = v;
    assign gen.freq_word_o = sel_cfg.freq;
    assign gen.pw_word_o   = sel_cfg.pw;
    assign gen.wave_sel_o  = sel_cfg.wave_sel;
    assign gen.sync_o      = sel_cfg.sync;
    assign gen.ring_mod_o  = sel_cfg.ring;
    assign voice0_o        = voice_q[0];
    assign voice1_o        = voice_q[1];
    assign voice2_o        = voice_q[2];
    assign state_o         = state;

endmodule
